daisy_io_bridge: RTL and testbench

Z80 I/O front end for the fake daisywheel controller. Decodes PCW ports 0x00FC/0x00FD/0x01FC from the CPU I/O bus, converts each bus cycle into one clean, level `sel` access with a guaranteed deasserted gap, and returns the daisy read data to the CPU. With logging compiled in, it also records every daisy write (port code + byte) in an 8-entry FIFO that the HPS side drains for debugging boot sequences.

---
 rtl/daisy_io_bridge.sv | 198 +++++++++++++++++++
 tb/tb_daisy_io_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/daisy_io_bridge.sv
// Z80 I/O front end for the daisywheel controller: decodes ports 0x00FC/0x00FD/0x01FC into level sel accesses.
// Optional write-capture FIFO for the HPS side is built when DAISY_LOG_EN is defined.
module daisy_io_bridge #(
    parameter int LOG_DEPTH_LOG2 = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_hit,
    output logic        sel,
    output logic [1:0]  address,
    output logic        wr,
    output logic [7:0]  din,
    input  logic [7:0]  dout,
    input  logic        log_rd,
    input  logic        log_clr,
    output logic [9:0]  log_data,
    output logic        log_empty,
    output logic        log_overflow
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_RECOVER = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_hit;
    logic        w_port_fc;
    logic        w_port_fd;
    logic [1:0]  w_code;
    logic        w_push;
    logic        r_sel;
    logic [1:0]  r_address;
    logic        r_wr;
    logic [7:0]  r_din;
    logic [7:0]  r_cpu_din;

    // Port decode: exactly one strobe low during IORQ
    always_comb begin
        w_port_fc = (cpu_addr[7:0] == 8'hFC);
        w_port_fd = (cpu_addr[7:0] == 8'hFD);
        w_hit     = !cpu_iorq_n && (cpu_rd_n != cpu_wr_n) && (w_port_fc || w_port_fd);
        if (w_port_fd) begin
            w_code = 2'b01;
        end else if (cpu_addr[15:8] == 8'h01) begin
            w_code = 2'b10;
        end else begin
            w_code = 2'b00;
        end
    end

    // Next-state logic; RECOVER forces one low sel cycle between accesses
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        if (ce) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        w_state_nxt = ST_ACCESS;
                        w_push      = !cpu_wr_n;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (w_hit) begin
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        w_state_nxt = ST_RECOVER;
                    end
                end
                ST_RECOVER: w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    // Registered bus-side outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sel     <= 1'b0;
            r_address <= 2'b00;
            r_wr      <= 1'b0;
            r_din     <= 8'h00;
            r_cpu_din <= 8'hFF;
        end else if (ce) begin
            r_sel <= (w_state_nxt == ST_ACCESS);
            if (r_state == ST_IDLE && w_hit) begin
                r_address <= w_code;
                r_wr      <= !cpu_wr_n;
                r_din     <= cpu_dout;
            end
            if (r_state == ST_ACCESS && !r_wr) begin
                r_cpu_din <= dout;
            end else begin
                r_cpu_din <= 8'hFF;
            end
        end
    end

    assign sel     = r_sel;
    assign address = r_address;
    assign wr      = r_wr;
    assign din     = r_din;
    assign cpu_din = r_cpu_din;
    assign cpu_hit = w_hit;

`ifdef DAISY_LOG_EN
    localparam int LP_DEPTH = 1 << LOG_DEPTH_LOG2;
    localparam logic [LOG_DEPTH_LOG2:0]   LP_FULL     = (LOG_DEPTH_LOG2 + 1)'(LP_DEPTH);
    localparam logic [LOG_DEPTH_LOG2:0]   LP_CNT_ZERO = (LOG_DEPTH_LOG2 + 1)'(0);
    localparam logic [LOG_DEPTH_LOG2:0]   LP_CNT_ONE  = (LOG_DEPTH_LOG2 + 1)'(1);
    localparam logic [LOG_DEPTH_LOG2-1:0] LP_PTR_ZERO = LOG_DEPTH_LOG2'(0);
    localparam logic [LOG_DEPTH_LOG2-1:0] LP_PTR_ONE  = LOG_DEPTH_LOG2'(1);

    logic [9:0]                r_log_mem [LP_DEPTH];
    logic [LOG_DEPTH_LOG2-1:0] r_wptr;
    logic [LOG_DEPTH_LOG2-1:0] r_rptr;
    logic [LOG_DEPTH_LOG2:0]   r_count;
    logic                      r_overflow;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop_ok;
    logic                      w_push_ok;

    // A full FIFO still accepts a push when a pop frees a slot on the same edge
    always_comb begin
        w_empty   = (r_count == LP_CNT_ZERO);
        w_full    = (r_count == LP_FULL);
        w_pop_ok  = log_rd && !w_empty;
        w_push_ok = w_push && (!w_full || w_pop_ok);
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk_sys) begin
        if (reset || log_clr) begin
            r_wptr     <= LP_PTR_ZERO;
            r_rptr     <= LP_PTR_ZERO;
            r_count    <= LP_CNT_ZERO;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + LP_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + LP_PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Capture storage
    always_ff @(posedge clk_sys) begin
        if (w_push_ok && !reset && !log_clr) begin
            r_log_mem[r_wptr] <= {w_code, cpu_dout};
        end
    end

    assign log_data     = w_empty ? 10'h000 : r_log_mem[r_rptr];
    assign log_empty    = w_empty;
    assign log_overflow = r_overflow;
`else
    logic w_unused_log;

    assign w_unused_log = ^{log_rd, log_clr, w_push, (LOG_DEPTH_LOG2 > 32'sd0)};
    assign log_data     = 10'h000;
    assign log_empty    = 1'b1;
    assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_daisy_io_bridge.sv
// Directed bench for daisy_io_bridge: table of single bus cycles plus hand sequences for recovery, ce gating, FIFO and reset.
module tb_daisy_io_bridge;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce;
    logic [15:0] cpu_addr;
    logic        cpu_iorq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_hit;
    logic        sel;
    logic [1:0]  address;
    logic        wr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        log_rd;
    logic        log_clr;
    logic [9:0]  log_data;
    logic        log_empty;
    logic        log_overflow;

    int n_total = 0;
    int n_pass  = 0;

    daisy_io_bridge #(.LOG_DEPTH_LOG2(3)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce),
        .cpu_addr(cpu_addr), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_hit(cpu_hit),
        .sel(sel), .address(address), .wr(wr), .din(din), .dout(dout),
        .log_rd(log_rd), .log_clr(log_clr), .log_data(log_data),
        .log_empty(log_empty), .log_overflow(log_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic        iorq_n;
        logic        rd_n;
        logic        wr_n;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        hit;
        logic [1:0]  code;
        logic        wr;
        logic [7:0]  cpu_din;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic bus_set(input logic iorq_n, input logic rd_n, input logic wr_n,
                           input logic [15:0] a, input logic [7:0] d);
        cpu_iorq_n = iorq_n;
        cpu_rd_n   = rd_n;
        cpu_wr_n   = wr_n;
        cpu_addr   = a;
        cpu_dout   = d;
    endtask

    task automatic bus_idle();
        bus_set(1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
    endtask

    task automatic do_out(input logic [15:0] a, input logic [7:0] d);
        bus_set(1'b0, 1'b1, 1'b0, a, d);
        tick();
        tick();
        bus_idle();
        tick();
        tick();
    endtask

    task automatic pop();
        log_rd = 1'b1;
        tick();
        log_rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " sel"},       {15'h0, sel},          16'h0000);
        chk({tag, " address"},   {14'h0, address},      16'h0000);
        chk({tag, " wr"},        {15'h0, wr},           16'h0000);
        chk({tag, " din"},       {8'h0, din},           16'h0000);
        chk({tag, " cpu_din"},   {8'h0, cpu_din},       16'h00FF);
        chk({tag, " log_empty"}, {15'h0, log_empty},    16'h0001);
        chk({tag, " log_data"},  {6'h0, log_data},      16'h0000);
        chk({tag, " overflow"},  {15'h0, log_overflow}, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; dout = 8'h00; log_rd = 1'b0; log_clr = 1'b0;
        bus_idle();

        vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h01FC, 8'h12, 8'h00, 1'b1, 2'b10, 1'b1, 8'hFF};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h00FC, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 8'hFF};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h00FD, 8'h5A, 8'hB1, 1'b1, 2'b01, 1'b0, 8'hB1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h00FE, 8'h33, 8'h00, 1'b0, 2'b00, 1'b0, 8'hFF};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h00FC, 8'h00, 8'h77, 1'b0, 2'b00, 1'b0, 8'hFF};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h37FD, 8'hC3, 8'h00, 1'b1, 2'b01, 1'b1, 8'hFF};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h02FC, 8'h9C, 8'h7E, 1'b1, 2'b00, 1'b0, 8'h7E};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h00FC, 8'h44, 8'h55, 1'b0, 2'b00, 1'b0, 8'hFF};

        do_reset();
        chk_reset_state("rst");
        chk("rst cpu_hit", {15'h0, cpu_hit}, 16'h0000);

        // Table of single bus cycles, each started from IDLE
        for (int i = 0; i < 8; i++) begin
            bus_set(vecs[i].iorq_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].addr, vecs[i].wdata);
            dout = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d cpu_hit", i), {15'h0, cpu_hit}, {15'h0, vecs[i].hit});
            tick();
            chk($sformatf("v%0d sel", i), {15'h0, sel}, {15'h0, vecs[i].hit});
            if (vecs[i].hit) begin
                chk($sformatf("v%0d address", i), {14'h0, address}, {14'h0, vecs[i].code});
                chk($sformatf("v%0d wr", i), {15'h0, wr}, {15'h0, vecs[i].wr});
                chk($sformatf("v%0d din", i), {8'h0, din}, {8'h0, vecs[i].wdata});
            end
            tick();
            chk($sformatf("v%0d cpu_din", i), {8'h0, cpu_din}, {8'h0, vecs[i].cpu_din});
            bus_idle();
            tick();
            chk($sformatf("v%0d sel release", i), {15'h0, sel}, 16'h0000);
            tick();
            chk($sformatf("v%0d cpu_din idle", i), {8'h0, cpu_din}, 16'h00FF);
        end
`ifdef DAISY_LOG_EN
        chk("tbl log 0", {6'h0, log_data}, 16'h0212);
        pop();
        chk("tbl log 1", {6'h0, log_data}, 16'h0000);
        chk("tbl log 1 nonempty", {15'h0, log_empty}, 16'h0000);
        pop();
        chk("tbl log 2", {6'h0, log_data}, 16'h01C3);
        pop();
        chk("tbl log empty", {15'h0, log_empty}, 16'h0001);
`else
        chk("tbl log_empty", {15'h0, log_empty}, 16'h0001);
        chk("tbl log_data", {6'h0, log_data}, 16'h0000);
`endif

        // Back-to-back OUTs: a hit during RECOVER waits for IDLE
        do_reset();
        bus_set(1'b0, 1'b1, 1'b0, 16'h01FC, 8'h12);
        tick();
        chk("b2b sel1", {15'h0, sel}, 16'h0001);
        tick();
        bus_idle();
        tick();
        chk("b2b gap a", {15'h0, sel}, 16'h0000);
        bus_set(1'b0, 1'b1, 1'b0, 16'h00FC, 8'h00);
        tick();
        chk("b2b gap b", {15'h0, sel}, 16'h0000);
        tick();
        chk("b2b sel2", {15'h0, sel}, 16'h0001);
        chk("b2b address2", {14'h0, address}, 16'h0000);
        chk("b2b din2", {8'h0, din}, 16'h0000);
        bus_idle();
        tick();
        tick();
`ifdef DAISY_LOG_EN
        chk("b2b log 0", {6'h0, log_data}, 16'h0212);
        pop();
        chk("b2b log 1", {6'h0, log_data}, 16'h0000);
        chk("b2b log 1 nonempty", {15'h0, log_empty}, 16'h0000);
        pop();
`endif
        chk("b2b log empty", {15'h0, log_empty}, 16'h0001);

        // ce gating: a hit is not accepted while ce is low
        ce = 1'b0;
        dout = 8'hE4;
        bus_set(1'b0, 1'b0, 1'b1, 16'h00FD, 8'h00);
        tick();
        tick();
        chk("ce0 sel", {15'h0, sel}, 16'h0000);
        chk("ce0 cpu_din", {8'h0, cpu_din}, 16'h00FF);
        ce = 1'b1;
        tick();
        chk("ce1 sel", {15'h0, sel}, 16'h0001);
        tick();
        chk("ce1 cpu_din", {8'h0, cpu_din}, 16'h00E4);
        bus_idle();
        tick();
        tick();
        chk("ce read not logged", {15'h0, log_empty}, 16'h0001);

`ifdef DAISY_LOG_EN
        // Overflow: ninth write is dropped
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            do_out(16'h00FC, 8'(i));
        end
        chk("ovf set", {15'h0, log_overflow}, 16'h0001);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf pop %0d", i), {6'h0, log_data}, 16'(i));
            pop();
        end
        chk("ovf drained", {15'h0, log_empty}, 16'h0001);
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        chk("clr overflow", {15'h0, log_overflow}, 16'h0000);

        // Full FIFO: pop and push on the same edge both succeed
        for (int i = 1; i <= 8; i++) begin
            do_out(16'h00FC, 8'(i));
        end
        chk("full no ovf", {15'h0, log_overflow}, 16'h0000);
        bus_set(1'b0, 1'b1, 1'b0, 16'h00FC, 8'h09);
        log_rd = 1'b1;
        tick();
        log_rd = 1'b0;
        chk("pp no ovf", {15'h0, log_overflow}, 16'h0000);
        chk("pp head", {6'h0, log_data}, 16'h0002);
        tick();
        bus_idle();
        tick();
        tick();
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("pp pop %0d", i), {6'h0, log_data}, 16'(i));
            pop();
        end
        chk("pp drained", {15'h0, log_empty}, 16'h0001);

        // Pop while empty is ignored
        pop();
        chk("empty pop", {15'h0, log_empty}, 16'h0001);
        do_out(16'h00FD, 8'hA5);
        chk("after empty pop", {6'h0, log_data}, 16'h01A5);
`endif

        // Reset in ACCESS: sel drops at once and FIFO is flushed
        bus_set(1'b0, 1'b1, 1'b0, 16'h01FC, 8'h44);
        tick();
        chk("mid sel", {15'h0, sel}, 16'h0001);
        reset = 1'b1;
        bus_idle();
        tick();
        chk_reset_state("midrst");
        reset = 1'b0;
        tick();
        chk("post rst sel", {15'h0, sel}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
